// File: rtl/piso_tx_arbiter.sv
// piso_tx_arbiter: round-robin owner of a shared PISO shift register.
// Drives Clear/Load/Data_In and qualifies the serial line with valid/last strobes.
module piso_tx_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 4
) (
  input  logic                     Clock,
  input  logic                     Clear_n,
  input  logic [NUM_REQ-1:0]       Req,
  input  logic [NUM_REQ*WIDTH-1:0] Req_Data,
  input  logic                     Abort,
  output logic [NUM_REQ-1:0]       Grant,
  output logic                     Busy,
  output logic                     Done,
  output logic                     Aborted,
  output logic                     Ser_Valid,
  output logic                     Ser_Last,
  output logic                     Piso_Clear,
  output logic                     Piso_Load,
  output logic [WIDTH-1:0]         Piso_Data
);
  localparam int PW = $clog2(NUM_REQ);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;
  state_t          state_q;
  logic [PW-1:0]   ptr_q;
  logic [PW-1:0]   win_d;
  logic [CW-1:0]   cnt_q;
  // Descending scan so the last hit is the first requester at or after ptr.
  always_comb begin
    win_d = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--)
      if (Req[PW'((int'(ptr_q) + i) % NUM_REQ)]) win_d = PW'((int'(ptr_q) + i) % NUM_REQ);
  end
  always_ff @(posedge Clock or negedge Clear_n) begin
    if (!Clear_n) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      cnt_q      <= '0;
      Grant      <= '0;
      Busy       <= 1'b0;
      Done       <= 1'b0;
      Aborted    <= 1'b0;
      Ser_Valid  <= 1'b0;
      Ser_Last   <= 1'b0;
      Piso_Load  <= 1'b0;
      Piso_Clear <= 1'b1;
      Piso_Data  <= '0;
    end else begin
      Done      <= 1'b0;
      Aborted   <= 1'b0;
      Piso_Load <= 1'b0;
      Ser_Last  <= 1'b0;
      Ser_Valid <= state_q == SHIFT;
      case (state_q)
        IDLE: if (|Req) begin
          state_q    <= LOAD;
          Grant      <= NUM_REQ'(1) << win_d;
          Piso_Data  <= Req_Data[int'(win_d)*WIDTH +: WIDTH];
          Piso_Load  <= 1'b1;
          Piso_Clear <= 1'b0;
          Busy       <= 1'b1;
          ptr_q      <= PW'((int'(win_d) + 1) % NUM_REQ);
        end
        LOAD, SHIFT: if (Abort) begin
          state_q    <= IDLE;
          Grant      <= '0;
          Busy       <= 1'b0;
          Piso_Clear <= 1'b1;
          Aborted    <= 1'b1;
        end else if (state_q == LOAD) begin
          state_q <= SHIFT;
          cnt_q   <= '0;
        end else if (cnt_q == CW'(WIDTH - 1)) begin
          state_q    <= DONE;
          Done       <= 1'b1;
          Ser_Last   <= 1'b1;
          Piso_Clear <= 1'b1;
        end else cnt_q <= cnt_q + 1'b1;
        DONE: begin
          state_q <= IDLE;
          Grant   <= '0;
          Busy    <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_piso_tx_arbiter.sv
// tb_piso_tx_arbiter: random frames against a round-robin/serial-word model,
// with a behavioural MSB-first shift register supplying the serial line.
module tb_piso_tx_arbiter;
  localparam int N  = 4;
  localparam int W  = 4;
  localparam int DW = N * W;
  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [N-1:0]  req = '0;
  logic [DW-1:0] data = '0;
  logic          abort = 1'b0;
  logic [N-1:0]  grant;
  logic          busy, done, aborted, ser_valid, ser_last, p_clear, p_load;
  logic [W-1:0]  p_data;
  logic [W-1:0]  sr;
  logic          so;
  int checks = 0, errors = 0, cyc = 0, m_ptr = 0;
  piso_tx_arbiter #(.NUM_REQ(N), .WIDTH(W)) dut (
    .Clock(clk), .Clear_n(rst_n), .Req(req), .Req_Data(data), .Abort(abort),
    .Grant(grant), .Busy(busy), .Done(done), .Aborted(aborted),
    .Ser_Valid(ser_valid), .Ser_Last(ser_last), .Piso_Clear(p_clear),
    .Piso_Load(p_load), .Piso_Data(p_data)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // Shift register: SO is the bit shifted out and holds through load/clear.
  always @(posedge clk) begin
    if (p_clear) sr <= '0;
    else if (p_load) sr <= p_data;
    else begin
      so <= sr[W-1];
      sr <= sr << 1;
    end
  end
  function automatic int pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++)
      if (((r >> ((p + k) % N)) & N'(1)) != '0) return (p + k) % N;
    return 0;
  endfunction
  task automatic observe_frame(input bit mut, output int gcyc);
    int win, nb, dc;
    logic [W-1:0] word, got;
    logic [N-1:0] oh;
    bit seen, bad_last, load_s0;
    win = pick(req, m_ptr);
    word = data[win*W +: W];
    oh = N'(1) << win;
    m_ptr = (win + 1) % N;
    @(negedge clk);
    for (int c = 0; c < 20 && grant === '0; c++) @(negedge clk);
    gcyc = cyc;
    checks++;
    if (grant !== oh) begin
      errors++;
      $display("FAIL grant: got %b want %b", grant, oh);
    end
    checks++;
    if ({p_load, p_clear, busy, p_data} !== {1'b1, 1'b0, 1'b1, word}) begin
      errors++;
      $display("FAIL load: load/clear/busy/data got %b%b%b %b want 101 %b", p_load, p_clear, busy, p_data, word);
    end
    got = '0; nb = 0; seen = 0; bad_last = 0; dc = 0; load_s0 = 1;
    for (int c = 1; c <= 8 && !seen; c++) begin
      @(negedge clk);
      if (c == 1) load_s0 = p_load;
      if (mut && c == 1) begin
        req = '0;
        data = ~data;
      end
      if (ser_valid === 1'b1) begin
        got = {got[W-2:0], so};
        nb++;
      end
      if (ser_last === 1'b1 && done !== 1'b1) bad_last = 1;
      if (done === 1'b1) begin
        seen = 1;
        dc = c;
        checks++;
        if (ser_last !== 1'b1 || grant !== oh || bad_last) begin
          errors++;
          $display("FAIL done_strobes: last %b grant %b early_last %0d want 1 %b 0", ser_last, grant, bad_last, oh);
        end
      end
    end
    checks++;
    if (!seen || dc != W + 1 || load_s0 !== 1'b0) begin
      errors++;
      $display("FAIL done_timing: seen %0d after %0d cycles load_s0 %b want 1 after %0d load_s0 0", seen, dc, load_s0, W + 1);
    end
    checks++;
    if (got !== word || nb != W) begin
      errors++;
      $display("FAIL serial: got %b (%0d bits) want %b (%0d bits)", got, nb, word, W);
    end
  endtask
  task automatic test_reset();
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({grant, busy, done, aborted, ser_valid, ser_last, p_load, p_clear, p_data} !== {{N{1'b0}}, 7'b0000001, {W{1'b0}}}) begin
      errors++;
      $display("FAIL reset_async: outputs %b %b%b%b%b%b%b%b %b", grant, busy, done, aborted, ser_valid, ser_last, p_load, p_clear, p_data);
    end
    req = '1;
    repeat (3) @(negedge clk);
    checks++;
    if (grant !== '0 || busy !== 1'b0 || p_clear !== 1'b1) begin
      errors++;
      $display("FAIL reset_hold: grant %b busy %b clear %b want 0 0 1", grant, busy, p_clear);
    end
    req = '0;
    rst_n = 1'b1;
    m_ptr = 0;
    @(negedge clk);
  endtask
  task automatic test_single();
    int g;
    data = DW'($urandom);
    data[2*W +: W] = 4'b1011;
    req = 4'b0100;
    observe_frame(0, g);
    req = '0;
    repeat (2) @(negedge clk);
  endtask
  task automatic test_round_robin();
    int g, prev;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    m_ptr = 0;
    req = '1;
    data = DW'($urandom);
    for (int k = 0; k < 5; k++) begin
      observe_frame(0, g);
      data = DW'($urandom);
      if (k > 0) begin
        checks++;
        if (g - prev != W + 3) begin
          errors++;
          $display("FAIL period: got %0d cycles want %0d", g - prev, W + 3);
        end
      end
      prev = g;
    end
  endtask
  task automatic test_pair();
    int g;
    req = 4'b1001;
    observe_frame(0, g);
    observe_frame(0, g);
    req = '0;
    repeat (2) @(negedge clk);
  endtask
  task automatic test_abort();
    int win, nv, g;
    bit dseen;
    req = '1;
    data = DW'($urandom);
    win = pick(req, m_ptr);
    @(negedge clk);
    for (int c = 0; c < 20 && grant === '0; c++) @(negedge clk);
    nv = 0; dseen = 0;
    @(negedge clk);
    nv += int'(ser_valid);
    @(negedge clk);
    nv += int'(ser_valid);
    abort = 1'b1;
    @(negedge clk);
    nv += int'(ser_valid);
    dseen = done;
    abort = 1'b0;
    checks++;
    if ({aborted, done, busy, p_clear, p_load} !== 5'b10010 || grant !== '0) begin
      errors++;
      $display("FAIL abort: aborted/done/busy/clear/load %b%b%b%b%b grant %b want 10010 0000", aborted, done, busy, p_clear, p_load, grant);
    end
    checks++;
    if (nv > 2 || dseen) begin
      errors++;
      $display("FAIL abort_valid: %0d valid cycles done %b want <=2 and 0", nv, dseen);
    end
    m_ptr = (win + 1) % N;
    observe_frame(0, g);
    abort = 1'b1;
    req = '0;
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if (aborted !== 1'b0 || busy !== 1'b0 || grant !== '0) begin
      errors++;
      $display("FAIL abort_in_done: aborted %b busy %b grant %b want 0 0 0", aborted, busy, grant);
    end
    repeat (2) @(negedge clk);
  endtask
  task automatic test_async_reset();
    int g;
    req = N'(1) << $urandom_range(N - 1, 0);
    data = DW'($urandom);
    @(negedge clk);
    for (int c = 0; c < 20 && grant === '0; c++) @(negedge clk);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({grant, busy, done, ser_valid, ser_last, p_load, p_clear, p_data} !== {{N{1'b0}}, 6'b000001, {W{1'b0}}}) begin
      errors++;
      $display("FAIL midframe_reset: grant %b busy %b done %b valid %b last %b load %b clear %b data %b", grant, busy, done, ser_valid, ser_last, p_load, p_clear, p_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    m_ptr = 0;
    req = '1;
    observe_frame(0, g);
    req = '0;
    repeat (2) @(negedge clk);
  endtask
  task automatic test_drop_req();
    int g;
    req = N'($urandom_range(2**N - 1, 1));
    data = DW'($urandom);
    observe_frame(1, g);
    repeat (2) @(negedge clk);
  endtask
  task automatic test_random();
    int g;
    for (int k = 0; k < 12; k++) begin
      req = N'($urandom_range(2**N - 1, 1));
      data = DW'($urandom);
      observe_frame(0, g);
    end
    req = '0;
    repeat (2) @(negedge clk);
  endtask
  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_pair();
    test_abort();
    test_async_reset();
    test_drop_req();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule

// File: doc/piso_tx_arbiter.md
Name: piso_tx_arbiter

Overview:
- Round-robin controller that shares one 4-bit parallel-in/serial-out shift register between NUM_REQ requesters.
- Arbitrates between requests and drives the shift register's Clear, Load and Data_In inputs.
- Counts shift cycles and qualifies the serial output with valid and last strobes.
- Sits between requester logic and the shift register. The shift register's SO pin is the serial line; this block does not re-register it.

Parameters:
NUM_REQ, 4, number of requesters (legal 2..8)
WIDTH, 4, word width; must equal the shift register width

Ports:
Clock  in  1  rising-edge clock shared with the shift register
Clear_n  in  1  reset, asynchronous, active-low
Req  in  NUM_REQ  per-requester request; held high until its Done
Req_Data  in  NUM_REQ*WIDTH  flat word bus; requester i occupies bits [i*WIDTH +: WIDTH]
Abort  in  1  cancel the frame in progress
Grant  out  NUM_REQ  one-hot owner of the current frame; 0 when idle
Busy  out  1  high in LOAD, SHIFT and DONE
Done  out  1  one-cycle pulse when the frame completes
Aborted  out  1  one-cycle pulse when a frame is cancelled
Ser_Valid  out  1  the shift register's SO carries a valid bit this cycle
Ser_Last  out  1  the shift register's SO carries bit 0 of the word this cycle
Piso_Clear  out  1  drives the shift register's Clear
Piso_Load  out  1  drives the shift register's Load
Piso_Data  out  WIDTH  drives the shift register's Data_In

Behaviour:
- All outputs are registered.
- Reset (Clear_n low, asynchronous) forces:
  - state IDLE, round-robin pointer 0;
  - Grant, Busy, Done, Aborted, Ser_Valid, Ser_Last, Piso_Load = 0;
  - Piso_Data = 0, Piso_Clear = 1.
- IDLE:
  - Piso_Clear = 1 holds the shift register empty.
  - If any Req bit is set, the winner is the first i with Req[i] = 1, searching ptr, ptr+1, ... modulo NUM_REQ.
  - On the next edge: state LOAD, Grant = onehot(winner), Piso_Data = winner's word, Piso_Load = 1, Piso_Clear = 0, Busy = 1.
- LOAD, 1 cycle: the shift register captures Piso_Data at the closing edge. Then state SHIFT, Piso_Load = 0, bit counter = 0.
- SHIFT, WIDTH cycles:
  - Piso_Load = 0 and Piso_Clear = 0, so the shift register shifts MSB first on each edge.
  - The counter increments each cycle; on count WIDTH-1 the next state is DONE.
- Ser_Valid is registered from (state == SHIFT). It is therefore high for exactly WIDTH consecutive cycles, starting the cycle after the first shift edge.
- Ser_Last = 1 only in the final Ser_Valid cycle, which is the DONE cycle.
- DONE, 1 cycle:
  - Done = 1 and Grant is still asserted.
  - Piso_Clear = 1 takes effect next edge; SO holds its value through the clear.
  - ptr = (winner+1) mod NUM_REQ.
  - Next state is always IDLE.
- Frame period: back-to-back frames take WIDTH+3 cycles from one grant to the next.
- Abort while in LOAD or SHIFT:
  - Next edge: state IDLE, Grant = 0, Busy = 0, Piso_Clear = 1, Piso_Load = 0, Aborted = 1 for one cycle.
  - No Done pulse. ptr advances past the aborted winner.
  - Ser_Valid may still be high in the cycle the abort takes effect; it is 0 thereafter.
- Abort in IDLE or DONE is ignored.
- Dropping Req after grant does not stop the frame; only Abort cancels.
- Req_Data is sampled only at the IDLE-to-LOAD edge; later changes to it have no effect.
- A single active requester is re-granted after its DONE/IDLE gap if Req is still high.
- Reset mid-frame: the asynchronous return to reset values is immediate; Done is not issued.

Test Plan:
- Reset release, Req = 0100, word 2 = 1011:
  - Grant = 0100 one cycle after Req is seen.
  - Piso_Load high 1 cycle.
  - Ser_Valid high 4 cycles with SO = 1,0,1,1.
  - Ser_Last and Done coincide with SO = 1 (bit 0).
- Req = 1111 held, distinct words: grants in order 0001, 0010, 0100, 1000, 0001, each WIDTH+3 = 7 cycles apart, each serialising its own word.
- Req = 1001 with ptr = 1: requester 3 wins first, then requester 0.
- Abort in the 2nd SHIFT cycle:
  - Aborted pulses, Done never pulses.
  - Piso_Clear = 1 next cycle, at most 2 Ser_Valid cycles seen.
  - The next grant goes to the following requester.
- Clear_n pulsed low mid-SHIFT: all outputs return to reset values without waiting for a clock; after release, arbitration restarts from ptr 0.
- Req dropped during SHIFT and Req_Data changed: the full original word is still serialised and Done is still pulsed.
